// File: rtl/console_writer.sv
// Text-console front end: turns a CPU byte stream into video-memory writes with a
// rolling cursor. Define CONSOLE_CLEAR_EN to build the full-screen clear (reset and 0x0C).
module console_writer #(
    parameter int COLS   = 50,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 11
) (
    input  logic                      CLK_CPU,
    input  logic                      reset,
    input  logic                      char_valid,
    input  logic [7:0]                char_data,
    output logic                      char_ready,
    output logic                      video_write_enable,
    output logic [7:0]                video_write_data,
    output logic [ADDR_W-1:0]         video_write_addr,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic                      busy
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_CNT_A = ADDR_W'(COLS - 1);
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);
`ifdef CONSOLE_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_SCR_A = ADDR_W'(COLS * ROWS - 1);
`endif

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLR_ROW    = 2'd1
`ifdef CONSOLE_CLEAR_EN
        ,
        CLR_SCREEN = 2'd2
`endif
    } state_t;

    state_t              state_r, state_s;
    logic [COL_W-1:0]    col_r, col_s;
    logic [ROW_W-1:0]    row_r, row_s;
    logic [ADDR_W-1:0]   row_base_r, row_base_s;
    logic [ADDR_W-1:0]   cnt_r, cnt_s;
    logic                lf_r, lf_s;
    logic                we_r, we_s;
    logic [7:0]          wdata_r, wdata_s;
    logic [ADDR_W-1:0]   waddr_r, waddr_s;

    logic                accept_s;
    logic [ROW_W-1:0]    next_row_s;
    logic [ADDR_W-1:0]   next_base_s;
    logic [ADDR_W-1:0]   cur_addr_s;

    assign char_ready         = (state_r == IDLE);
    assign busy               = (state_r != IDLE);
    assign accept_s           = char_valid && (state_r == IDLE);
    assign cur_addr_s         = row_base_r + ADDR_W'(col_r);
    assign video_write_enable = we_r;
    assign video_write_data   = wdata_r;
    assign video_write_addr   = waddr_r;
    assign cursor_col         = col_r;
    assign cursor_row         = row_r;

    // Row advance with circular wrap; row_base tracks row*COLS without a multiplier
    always_comb begin
        if (row_r == LAST_ROW) begin
            next_row_s  = '0;
            next_base_s = '0;
        end else begin
            next_row_s  = row_r + ROW_W'(1);
            next_base_s = row_base_r + COLS_A;
        end
    end

    // Next-state, cursor and write-port logic
    always_comb begin
        state_s    = state_r;
        col_s      = col_r;
        row_s      = row_r;
        row_base_s = row_base_r;
        cnt_s      = cnt_r;
        lf_s       = lf_r;
        we_s       = 1'b0;
        wdata_s    = wdata_r;
        waddr_s    = waddr_r;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    case (char_data)
                        CH_CR: begin
                            col_s = '0;
                        end
                        CH_LF: begin
                            // LF issues the first clear write itself, so the row
                            // clear then only needs offsets 1..COLS-1
                            col_s      = '0;
                            row_s      = next_row_s;
                            row_base_s = next_base_s;
                            we_s       = 1'b1;
                            wdata_s    = CH_SPACE;
                            waddr_s    = next_base_s;
                            cnt_s      = ADDR_W'(1);
                            lf_s       = 1'b1;
                            state_s    = CLR_ROW;
                        end
                        CH_BS: begin
                            if (col_r != '0) begin
                                col_s   = col_r - COL_W'(1);
                                we_s    = 1'b1;
                                wdata_s = CH_SPACE;
                                waddr_s = cur_addr_s - ADDR_W'(1);
                            end else begin
                                col_s = col_r;
                            end
                        end
                        CH_FF: begin
`ifdef CONSOLE_CLEAR_EN
                            col_s      = '0;
                            row_s      = '0;
                            row_base_s = '0;
                            cnt_s      = '0;
                            state_s    = CLR_SCREEN;
`else
                            state_s    = IDLE;
`endif
                        end
                        default: begin
                            we_s    = 1'b1;
                            wdata_s = char_data;
                            waddr_s = cur_addr_s;
                            if (col_r == LAST_COL) begin
                                col_s      = '0;
                                row_s      = next_row_s;
                                row_base_s = next_base_s;
                                cnt_s      = '0;
                                lf_s       = 1'b0;
                                state_s    = CLR_ROW;
                            end else begin
                                col_s = col_r + COL_W'(1);
                            end
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end

            CLR_ROW: begin
                if (cnt_r < COLS_A) begin
                    we_s    = 1'b1;
                    wdata_s = CH_SPACE;
                    waddr_s = row_base_r + cnt_r;
                end else begin
                    we_s = 1'b0;
                end
                cnt_s = cnt_r + ADDR_W'(1);
                // Both paths hold char_ready low for exactly COLS cycles
                if ((lf_r && (cnt_r == COLS_A)) || (!lf_r && (cnt_r == LAST_CNT_A))) begin
                    state_s = IDLE;
                end else begin
                    state_s = CLR_ROW;
                end
            end

`ifdef CONSOLE_CLEAR_EN
            CLR_SCREEN: begin
                we_s    = 1'b1;
                wdata_s = CH_SPACE;
                waddr_s = cnt_r;
                cnt_s   = cnt_r + ADDR_W'(1);
                if (cnt_r == LAST_SCR_A) begin
                    state_s = IDLE;
                end else begin
                    state_s = CLR_SCREEN;
                end
            end
`endif

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any clear in progress
    always_ff @(posedge CLK_CPU or posedge reset) begin
        if (reset) begin
`ifdef CONSOLE_CLEAR_EN
            state_r <= CLR_SCREEN;
`else
            state_r <= IDLE;
`endif
            col_r      <= '0;
            row_r      <= '0;
            row_base_r <= '0;
            cnt_r      <= '0;
            lf_r       <= 1'b0;
            we_r       <= 1'b0;
            wdata_r    <= 8'h00;
            waddr_r    <= '0;
        end else begin
            state_r    <= state_s;
            col_r      <= col_s;
            row_r      <= row_s;
            row_base_r <= row_base_s;
            cnt_r      <= cnt_s;
            lf_r       <= lf_s;
            we_r       <= we_s;
            wdata_r    <= wdata_s;
            waddr_r    <= waddr_s;
        end
    end

endmodule

// File: tb/tb_console_writer.sv
// Directed self-checking bench for console_writer; macro-dependent scenarios follow
// CONSOLE_CLEAR_EN.
module tb_console_writer;

    logic        CLK_CPU = 1'b0;
    logic        reset = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic        video_write_enable;
    logic [7:0]  video_write_data;
    logic [10:0] video_write_addr;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    console_writer #(.COLS(50), .ROWS(30), .ADDR_W(11)) dut (
        .CLK_CPU            (CLK_CPU),
        .reset              (reset),
        .char_valid         (char_valid),
        .char_data          (char_data),
        .char_ready         (char_ready),
        .video_write_enable (video_write_enable),
        .video_write_data   (video_write_data),
        .video_write_addr   (video_write_addr),
        .cursor_col         (cursor_col),
        .cursor_row         (cursor_row),
        .busy               (busy)
    );

    always #5 CLK_CPU = ~CLK_CPU;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a byte, wait (bounded) for acceptance, return 1ns into cycle N+1
    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        char_valid = 1'b1;
        char_data  = b;
        while (char_ready !== 1'b1 && w < 5000) begin
            @(posedge CLK_CPU); #1;
            w++;
        end
        if (w >= 5000) begin
            compared++; mismatched++;
            $display("FAIL send_timeout: byte %h not accepted, char_ready=%b required 1", b, char_ready);
        end
        @(posedge CLK_CPU); #1;
        char_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_rdy;
`ifdef CONSOLE_CLEAR_EN
        exp_rdy = 1'b0;
        char_valid = 1'b1;
        char_data  = 8'h51;
`else
        exp_rdy = 1'b1;
        char_valid = 1'b0;
`endif
        reset = 1'b1;
        repeat (3) @(posedge CLK_CPU);
        #1;
        compared++;
        if ({video_write_enable, video_write_data, video_write_addr, cursor_col, cursor_row} !== 31'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: we=%b data=%h addr=%0d col=%0d row=%0d required all 0",
                     video_write_enable, video_write_data, video_write_addr, cursor_col, cursor_row);
        end
        compared++;
        if (char_ready !== exp_rdy || busy !== ~exp_rdy) begin
            mismatched++;
            $display("FAIL reset_ready: ready=%b busy=%b required ready=%b", char_ready, busy, exp_rdy);
        end
        reset = 1'b0;
`ifdef CONSOLE_CLEAR_EN
        for (int i = 0; i < 1500; i++) begin
            @(posedge CLK_CPU); #1;
            compared++;
            if (video_write_enable !== 1'b1 || video_write_addr !== 11'(i) ||
                video_write_data !== 8'h20 || char_ready !== (i == 1499)) begin
                mismatched++;
                $display("FAIL power_clear[%0d]: we=%b addr=%0d data=%h ready=%b required 1/%0d/20/%b",
                         i, video_write_enable, video_write_addr, video_write_data, char_ready, i, (i == 1499));
            end
        end
        @(posedge CLK_CPU); #1;
        char_valid = 1'b0;
        compared++;
        if (video_write_enable !== 1'b1 || video_write_addr !== 11'd0 ||
            video_write_data !== 8'h51 || cursor_col !== 6'd1) begin
            mismatched++;
            $display("FAIL first_accept: we=%b addr=%0d data=%h col=%0d required 1/0/51/1",
                     video_write_enable, video_write_addr, video_write_data, cursor_col);
        end
        send(8'h0D);
`else
        @(posedge CLK_CPU); #1;
`endif
    endtask

    task automatic test_back_to_back();
        char_valid = 1'b1;
        char_data  = 8'h41;
        @(posedge CLK_CPU); #1;
        char_data  = 8'h42;
        compared++;
        if (video_write_enable !== 1'b1 || video_write_addr !== 11'd0 || video_write_data !== 8'h41 ||
            char_ready !== 1'b1 || cursor_col !== 6'd1) begin
            mismatched++;
            $display("FAIL b2b_A: we=%b addr=%0d data=%h ready=%b col=%0d required 1/0/41/1/1",
                     video_write_enable, video_write_addr, video_write_data, char_ready, cursor_col);
        end
        @(posedge CLK_CPU); #1;
        char_valid = 1'b0;
        compared++;
        if (video_write_enable !== 1'b1 || video_write_addr !== 11'd1 || video_write_data !== 8'h42 ||
            cursor_col !== 6'd2 || cursor_row !== 5'd0) begin
            mismatched++;
            $display("FAIL b2b_B: we=%b addr=%0d data=%h col=%0d row=%0d required 1/1/42/2/0",
                     video_write_enable, video_write_addr, video_write_data, cursor_col, cursor_row);
        end
        @(posedge CLK_CPU); #1;
        compared++;
        if (video_write_enable !== 1'b0 || video_write_addr !== 11'd1 || video_write_data !== 8'h42) begin
            mismatched++;
            $display("FAIL idle_hold: we=%b addr=%0d data=%h required 0/1/42",
                     video_write_enable, video_write_addr, video_write_data);
        end
    endtask

    task automatic test_wrap();
        send(8'h0D);
        send(8'h0A);
        send(8'h0A);
        repeat (49) send(8'h2E);
        compared++;
        if (cursor_col !== 6'd49 || cursor_row !== 5'd2) begin
            mismatched++;
            $display("FAIL wrap_setup: col=%0d row=%0d required 49/2", cursor_col, cursor_row);
        end
        send(8'h5A);
        char_valid = 1'b1;
        char_data  = 8'h60;
        compared++;
        if (video_write_enable !== 1'b1 || video_write_addr !== 11'd149 || video_write_data !== 8'h5A ||
            cursor_col !== 6'd0 || cursor_row !== 5'd3 || char_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL wrap_char: we=%b addr=%0d data=%h col=%0d row=%0d ready=%b required 1/149/5a/0/3/0",
                     video_write_enable, video_write_addr, video_write_data, cursor_col, cursor_row, char_ready);
        end
        for (int k = 0; k < 50; k++) begin
            @(posedge CLK_CPU); #1;
            compared++;
            if (video_write_enable !== 1'b1 || video_write_addr !== 11'(150 + k) ||
                video_write_data !== 8'h20 || char_ready !== (k == 49)) begin
                mismatched++;
                $display("FAIL wrap_clear[%0d]: we=%b addr=%0d data=%h ready=%b required 1/%0d/20/%b",
                         k, video_write_enable, video_write_addr, video_write_data, char_ready, 150 + k, (k == 49));
            end
            char_data = (k == 49) ? 8'h59 : 8'(8'h61 + k);
        end
        @(posedge CLK_CPU); #1;
        char_valid = 1'b0;
        compared++;
        if (video_write_enable !== 1'b1 || video_write_addr !== 11'd150 || video_write_data !== 8'h59 ||
            cursor_col !== 6'd1 || cursor_row !== 5'd3) begin
            mismatched++;
            $display("FAIL wrap_next: we=%b addr=%0d data=%h col=%0d row=%0d required 1/150/59/1/3",
                     video_write_enable, video_write_addr, video_write_data, cursor_col, cursor_row);
        end
        send(8'h0D);
    endtask

    task automatic test_lf_wrap();
        repeat (26) send(8'h0A);
        repeat (10) send(8'h2E);
        compared++;
        if (cursor_col !== 6'd10 || cursor_row !== 5'd29) begin
            mismatched++;
            $display("FAIL lf_setup: col=%0d row=%0d required 10/29", cursor_col, cursor_row);
        end
        send(8'h0A);
        compared++;
        if (video_write_enable !== 1'b1 || video_write_addr !== 11'd0 || video_write_data !== 8'h20 ||
            cursor_col !== 6'd0 || cursor_row !== 5'd0 || char_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL lf_first: we=%b addr=%0d data=%h col=%0d row=%0d ready=%b required 1/0/20/0/0/0",
                     video_write_enable, video_write_addr, video_write_data, cursor_col, cursor_row, char_ready);
        end
        for (int k = 1; k < 50; k++) begin
            @(posedge CLK_CPU); #1;
            compared++;
            if (video_write_enable !== 1'b1 || video_write_addr !== 11'(k) ||
                video_write_data !== 8'h20 || char_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL lf_clear[%0d]: we=%b addr=%0d data=%h ready=%b required 1/%0d/20/0",
                         k, video_write_enable, video_write_addr, video_write_data, char_ready, k);
            end
        end
        @(posedge CLK_CPU); #1;
        compared++;
        if (char_ready !== 1'b1 || video_write_enable !== 1'b0) begin
            mismatched++;
            $display("FAIL lf_done: ready=%b we=%b required 1/0", char_ready, video_write_enable);
        end
        send(8'h2E);
        compared++;
        if (video_write_addr !== 11'd0 || video_write_data !== 8'h2E || cursor_col !== 6'd1) begin
            mismatched++;
            $display("FAIL lf_base: addr=%0d data=%h col=%0d required 0/2e/1",
                     video_write_addr, video_write_data, cursor_col);
        end
        send(8'h0D);
    endtask

    task automatic test_bs_cr();
        repeat (4) send(8'h0A);
        send(8'h08);
        compared++;
        if (video_write_enable !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 5'd4 || char_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL bs_col0: we=%b col=%0d row=%0d ready=%b required 0/0/4/1",
                     video_write_enable, cursor_col, cursor_row, char_ready);
        end
        send(8'h01);
        compared++;
        if (video_write_enable !== 1'b1 || video_write_addr !== 11'd200 || video_write_data !== 8'h01 ||
            cursor_col !== 6'd1) begin
            mismatched++;
            $display("FAIL ctrl_glyph: we=%b addr=%0d data=%h col=%0d required 1/200/01/1",
                     video_write_enable, video_write_addr, video_write_data, cursor_col);
        end
        repeat (6) send(8'h2E);
        send(8'h08);
        compared++;
        if (video_write_enable !== 1'b1 || video_write_addr !== 11'd206 || video_write_data !== 8'h20 ||
            cursor_col !== 6'd6 || cursor_row !== 5'd4) begin
            mismatched++;
            $display("FAIL bs_erase: we=%b addr=%0d data=%h col=%0d row=%0d required 1/206/20/6/4",
                     video_write_enable, video_write_addr, video_write_data, cursor_col, cursor_row);
        end
        send(8'h2E);
        send(8'h0D);
        compared++;
        if (video_write_enable !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 5'd4 || char_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL cr: we=%b col=%0d row=%0d ready=%b required 0/0/4/1",
                     video_write_enable, cursor_col, cursor_row, char_ready);
        end
    endtask

    task automatic test_form_feed();
`ifdef CONSOLE_CLEAR_EN
        int w;
        send(8'h0A);
        repeat (5) send(8'h2E);
        compared++;
        if (cursor_col !== 6'd5 || cursor_row !== 5'd5) begin
            mismatched++;
            $display("FAIL ff_setup: col=%0d row=%0d required 5/5", cursor_col, cursor_row);
        end
        send(8'h0C);
        compared++;
        if (video_write_enable !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 5'd0 ||
            char_ready !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL ff_start: we=%b col=%0d row=%0d ready=%b busy=%b required 0/0/0/0/1",
                     video_write_enable, cursor_col, cursor_row, char_ready, busy);
        end
        for (int i = 0; i < 700; i++) begin
            @(posedge CLK_CPU); #1;
            compared++;
            if (video_write_enable !== 1'b1 || video_write_addr !== 11'(i) ||
                video_write_data !== 8'h20 || char_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL ff_clear[%0d]: we=%b addr=%0d data=%h ready=%b required 1/%0d/20/0",
                         i, video_write_enable, video_write_addr, video_write_data, char_ready, i);
            end
        end
        reset = 1'b1;
        #1;
        compared++;
        if ({video_write_enable, video_write_data, video_write_addr, cursor_col, cursor_row} !== 31'd0 ||
            char_ready !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL midclear_reset: we=%b data=%h addr=%0d col=%0d row=%0d ready=%b required zeros, ready 0",
                     video_write_enable, video_write_data, video_write_addr, cursor_col, cursor_row, char_ready);
        end
        @(posedge CLK_CPU); #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK_CPU); #1;
            compared++;
            if (video_write_enable !== 1'b1 || video_write_addr !== 11'(i) || video_write_data !== 8'h20) begin
                mismatched++;
                $display("FAIL restart_clear[%0d]: we=%b addr=%0d data=%h required 1/%0d/20",
                         i, video_write_enable, video_write_addr, video_write_data, i);
            end
        end
        w = 0;
        while (char_ready !== 1'b1 && w < 2000) begin
            @(posedge CLK_CPU); #1;
            w++;
        end
        compared++;
        if (char_ready !== 1'b1 || video_write_addr !== 11'd1499) begin
            mismatched++;
            $display("FAIL restart_done: ready=%b addr=%0d required 1/1499", char_ready, video_write_addr);
        end
`else
        send(8'h2E);
        send(8'h0C);
        compared++;
        if (video_write_enable !== 1'b0 || cursor_col !== 6'd1 || cursor_row !== 5'd4 ||
            char_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL ff_noop: we=%b col=%0d row=%0d ready=%b busy=%b required 0/1/4/1/0",
                     video_write_enable, cursor_col, cursor_row, char_ready, busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wrap();
        test_lf_wrap();
        test_bs_cr();
        test_form_feed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
